mux2to1_sync: RTL and testbench

- Parameterised-width 2:1 selector for the 64-bit ALU datapath (operand/result steering).
- Provides an immediate combinational output plus a registered copy with a valid flag and a select-toggle counter for debug/coverage.
- Used at widths 1 and 8 in unit tests; 64 in the ALU.

---
 rtl/mux2to1_sync.sv | 88 ++++++++
 tb/tb_mux2to1_sync.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2to1_sync.sv
// 2:1 selector with a combinational output plus a registered copy, a valid flag
// and a saturating select-toggle counter for debug/coverage.
// Optional feature: define MUX2TO1_SYNC_PARITY_EN to add parity_q, the XOR of out_q.
module mux2to1_sync #(
    parameter int unsigned w     = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [w-1:0]     in_0,
    input  logic [w-1:0]     in_1,
    input  logic             sel,
    input  logic             en,
    output logic [w-1:0]     out,
    output logic [w-1:0]     out_q,
    output logic             valid_q,
    output logic [CNT_W-1:0] sel_toggles
`ifdef MUX2TO1_SYNC_PARITY_EN
    ,
    output logic             parity_q
`endif
);

    logic [w-1:0]     out_d;
    logic             valid_d;
    logic             last_sel_q;
    logic             last_sel_d;
    logic [CNT_W-1:0] toggles_d;
    logic             toggle_hit;
`ifdef MUX2TO1_SYNC_PARITY_EN
    logic             parity_d;
`endif

    // Zero-latency select; the ternary merges bitwise so an unknown sel with equal inputs
    // still yields that input value.
    always_comb begin
        out = sel ? in_1 : in_0;
    end

    // A toggle needs a prior capture (valid_q) so the first capture after reset never counts.
    always_comb begin
        toggle_hit = valid_q && (sel != last_sel_q) && (sel_toggles != {CNT_W{1'b1}});
    end

    // Next-state: everything loads together on en, otherwise holds.
    always_comb begin
        out_d      = out_q;
        valid_d    = valid_q;
        last_sel_d = last_sel_q;
        toggles_d  = sel_toggles;
`ifdef MUX2TO1_SYNC_PARITY_EN
        parity_d   = parity_q;
`endif
        if (en) begin
            out_d      = out;
            valid_d    = 1'b1;
            last_sel_d = sel;
            if (toggle_hit) begin
                toggles_d = sel_toggles + {{(CNT_W-1){1'b0}}, 1'b1};
            end
`ifdef MUX2TO1_SYNC_PARITY_EN
            parity_d   = ^out;
`endif
        end
    end

    // State registers, cleared immediately by reset regardless of en.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_q       <= '0;
            valid_q     <= 1'b0;
            last_sel_q  <= 1'b0;
            sel_toggles <= '0;
`ifdef MUX2TO1_SYNC_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            out_q       <= out_d;
            valid_q     <= valid_d;
            last_sel_q  <= last_sel_d;
            sel_toggles <= toggles_d;
`ifdef MUX2TO1_SYNC_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_mux2to1_sync.sv
// Directed self-checking bench for mux2to1_sync at w=1, w=8 and a 2-bit counter variant.
module tb_mux2to1_sync;

    int errors = 0;
    int checks = 0;

    logic clk = 1'b0;
    logic rst_b = 1'b0;

    // w=1 instance
    logic       a1, b1, s1;
    logic       en1 = 1'b0;
    logic       out1, outq1, valid1;
    logic [7:0] tog1;

    // w=8 instances share stimulus
    logic [7:0] in_0, in_1;
    logic       sel, en;
    logic [7:0] out8, outq8, outq_sat, out_sat;
    logic       valid8, valid_sat;
    logic [7:0] tog8;
    logic [1:0] tog_sat;
`ifdef MUX2TO1_SYNC_PARITY_EN
    logic       par1, par8, par_sat;
`endif

    always #5 clk = ~clk;

    mux2to1_sync #(.w(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_b(rst_b), .in_0(a1), .in_1(b1), .sel(s1), .en(en1),
        .out(out1), .out_q(outq1), .valid_q(valid1), .sel_toggles(tog1)
`ifdef MUX2TO1_SYNC_PARITY_EN
        , .parity_q(par1)
`endif
    );

    mux2to1_sync #(.w(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst_b(rst_b), .in_0(in_0), .in_1(in_1), .sel(sel), .en(en),
        .out(out8), .out_q(outq8), .valid_q(valid8), .sel_toggles(tog8)
`ifdef MUX2TO1_SYNC_PARITY_EN
        , .parity_q(par8)
`endif
    );

    mux2to1_sync #(.w(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_b(rst_b), .in_0(in_0), .in_1(in_1), .sel(sel), .en(en),
        .out(out_sat), .out_q(outq_sat), .valid_q(valid_sat), .sel_toggles(tog_sat)
`ifdef MUX2TO1_SYNC_PARITY_EN
        , .parity_q(par_sat)
`endif
    );

    // Drive one set of inputs between edges, then step past the next rising edge.
    task automatic cap(input logic s, input logic [7:0] a, input logic [7:0] b, input logic e);
        @(negedge clk);
        sel  = s;
        in_0 = a;
        in_1 = b;
        en   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_b = 1'b0;
        en    = 1'b1;
        sel   = 1'b1;
        in_0  = 8'h12;
        in_1  = 8'h34;
        a1 = 1'b1; b1 = 1'b0; s1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (outq8 !== 8'h00) begin errors++; $display("FAIL reset_outq: got %h want 00", outq8); end
        checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid8); end
        checks++; if (tog8 !== 8'h00) begin errors++; $display("FAIL reset_tog: got %h want 00", tog8); end
        checks++; if (tog_sat !== 2'b00) begin errors++; $display("FAIL reset_tog_sat: got %b want 00", tog_sat); end
        checks++; if (outq1 !== 1'b0 || valid1 !== 1'b0 || tog1 !== 8'h00) begin
            errors++; $display("FAIL reset_w1: got outq=%b valid=%b tog=%h want 0 0 00", outq1, valid1, tog1);
        end
        checks++; if (out8 !== 8'h34) begin errors++; $display("FAIL reset_out_follows_sel1: got %h want 34", out8); end
        sel = 1'b0;
        #1;
        checks++; if (out8 !== 8'h12) begin errors++; $display("FAIL reset_out_follows_sel0: got %h want 12", out8); end
        checks++; if (out_sat !== 8'h12) begin errors++; $display("FAIL reset_out_sat: got %h want 12", out_sat); end
`ifdef MUX2TO1_SYNC_PARITY_EN
        checks++; if (par1 !== 1'b0 || par8 !== 1'b0 || par_sat !== 1'b0) begin
            errors++; $display("FAIL reset_parity: got %b%b%b want 000", par1, par8, par_sat);
        end
`endif
    endtask

    task automatic test_comb_w1;
        logic [7:0] exp_bits;
        logic [2:0] v;
        exp_bits = 8'b1101_1000; // bit k is expected out for {in_0,in_1,sel}=k
        for (int k = 0; k < 8; k++) begin
            v  = 3'(k);
            a1 = v[2];
            b1 = v[1];
            s1 = v[0];
            #10;
            checks++;
            if (out1 !== exp_bits[k]) begin
                errors++; $display("FAIL comb_w1[%0d]: got %b want %b", k, out1, exp_bits[k]);
            end
        end
    endtask

    localparam logic [7:0] VA [10] = '{8'h00, 8'h80, 8'h9C, 8'hFB, 8'h01,
                                       8'hC8, 8'h7F, 8'hAA, 8'hF0, 8'hE7};
    localparam logic [7:0] VB [10] = '{8'hFF, 8'h7F, 8'h64, 8'h05, 8'hFE,
                                       8'h38, 8'h80, 8'h55, 8'h0F, 8'h19};
    localparam logic [9:0] VS = 10'b01_0101_0101; // bit i is sel for vector i
    localparam logic [7:0] VE [10] = '{8'hFF, 8'h80, 8'h64, 8'hFB, 8'hFE,
                                       8'hC8, 8'h80, 8'hAA, 8'h0F, 8'hE7};

    task automatic test_comb_w8;
        logic [9:0] sv;
        sv = VS;
        in_0 = 8'hFB;
        in_1 = 8'd100;
        sel  = 1'b0;
        #1;
        checks++; if (out8 !== 8'hFB) begin errors++; $display("FAIL comb_neg5: got %h want fb", out8); end
        sel = 1'b1;
        #1;
        checks++; if (out8 !== 8'h64) begin errors++; $display("FAIL comb_100: got %h want 64", out8); end
        for (int i = 0; i < 10; i++) begin
            in_0 = VA[i];
            in_1 = VB[i];
            sel  = sv[i];
            #1;
            checks++;
            if (out8 !== VE[i]) begin
                errors++; $display("FAIL comb_vec[%0d]: got %h want %h", i, out8, VE[i]);
            end
        end
        // Equal inputs must pass through whatever sel is.
        in_0 = 8'h3C;
        in_1 = 8'h3C;
        sel  = 1'bx;
        #1;
        checks++; if (out8 !== 8'h3C) begin errors++; $display("FAIL comb_selx_equal: got %h want 3c", out8); end
        sel = 1'b0;
    endtask

    task automatic release_reset;
        @(negedge clk);
        en    = 1'b0;
        rst_b = 1'b1;
    endtask

    task automatic test_capture;
        logic [7:0] exp_q   [4];
        logic [7:0] exp_tog [4];
        logic [3:0] ss;
        exp_q   = '{8'h11, 8'h22, 8'h22, 8'h11};
        exp_tog = '{8'd0, 8'd1, 8'd1, 8'd2};
        ss      = 4'b0110; // sel order 0,1,1,0
        // Nothing captured yet after release.
        @(posedge clk);
        #1;
        checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL cap_idle_valid: got %b want 0", valid8); end
        for (int i = 0; i < 4; i++) begin
            cap(ss[3-i], 8'h11, 8'h22, 1'b1);
            checks++;
            if (outq8 !== exp_q[i] || valid8 !== 1'b1 || tog8 !== exp_tog[i]) begin
                errors++;
                $display("FAIL cap[%0d]: got q=%h v=%b tog=%0d want q=%h v=1 tog=%0d",
                         i, outq8, valid8, tog8, exp_q[i], exp_tog[i]);
            end
        end
    endtask

    task automatic test_hold;
        for (int i = 0; i < 3; i++) begin
            cap(1'b1, 8'h5A, 8'hA5, 1'b0);
        end
        checks++;
        if (outq8 !== 8'h11 || valid8 !== 1'b1 || tog8 !== 8'd2) begin
            errors++; $display("FAIL hold: got q=%h v=%b tog=%0d want q=11 v=1 tog=2", outq8, valid8, tog8);
        end
        checks++; if (out8 !== 8'hA5) begin errors++; $display("FAIL hold_out: got %h want a5", out8); end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        en = 1'b1;
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if (outq8 !== 8'h00 || valid8 !== 1'b0 || tog8 !== 8'd0) begin
            errors++; $display("FAIL async_reset: got q=%h v=%b tog=%0d want 00 0 0", outq8, valid8, tog8);
        end
        @(posedge clk);
        #1;
        checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL async_reset_hold: got %b want 0", valid8); end
        release_reset();
    endtask

    task automatic test_first_capture;
        cap(1'b1, 8'h01, 8'h02, 1'b1);
        checks++;
        if (outq8 !== 8'h02 || valid8 !== 1'b1 || tog8 !== 8'd0) begin
            errors++; $display("FAIL first_cap: got q=%h v=%b tog=%0d want 02 1 0", outq8, valid8, tog8);
        end
        cap(1'b0, 8'h03, 8'h04, 1'b1);
        checks++; if (tog8 !== 8'd1) begin errors++; $display("FAIL first_cap_next: got %0d want 1", tog8); end
    endtask

    task automatic test_saturation;
        logic [1:0] exp_sat  [6];
        logic [7:0] exp_wide [6];
        exp_sat  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        exp_wide = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        release_reset();
        for (int i = 0; i < 6; i++) begin
            cap(i[0], 8'h40, 8'h41, 1'b1);
            checks++;
            if (tog_sat !== exp_sat[i] || tog8 !== exp_wide[i]) begin
                errors++;
                $display("FAIL sat[%0d]: got sat=%0d wide=%0d want sat=%0d wide=%0d",
                         i, tog_sat, tog8, exp_sat[i], exp_wide[i]);
            end
        end
        checks++;
        if (outq_sat !== 8'h41 || valid_sat !== 1'b1 || out_sat !== 8'h41) begin
            errors++; $display("FAIL sat_data: got q=%h v=%b out=%h want 41 1 41", outq_sat, valid_sat, out_sat);
        end
    endtask

`ifdef MUX2TO1_SYNC_PARITY_EN
    task automatic test_parity;
        cap(1'b0, 8'hB4, 8'h00, 1'b1);
        checks++; if (par8 !== 1'b0) begin errors++; $display("FAIL parity_b4: got %b want 0", par8); end
        cap(1'b1, 8'h00, 8'h07, 1'b1);
        checks++; if (par8 !== 1'b1) begin errors++; $display("FAIL parity_07: got %b want 1", par8); end
        cap(1'b1, 8'h00, 8'hFF, 1'b0);
        checks++; if (par8 !== 1'b1) begin errors++; $display("FAIL parity_hold: got %b want 1", par8); end
    endtask
`endif

    initial begin
        in_0 = 8'h00;
        in_1 = 8'h00;
        sel  = 1'b0;
        en   = 1'b0;
        a1 = 1'b0; b1 = 1'b0; s1 = 1'b0;
        test_reset();
        test_comb_w1();
        test_comb_w8();
        release_reset();
        test_capture();
        test_hold();
        test_async_reset();
        test_first_capture();
        test_saturation();
`ifdef MUX2TO1_SYNC_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
